// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts a Q16.16 (x, y) pair into magnitude and
// atan2 angle (degrees * 2^16). One micro-rotation per clock, with a
// handshake on both the input and the result side.
module cordic_vector #(
  parameter int          ITER = 16,
  parameter logic [31:0] K    = 32'h09B74
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic signed [31:0] X_In,
  input  logic signed [31:0] Y_In,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic        [31:0] Magnitude,
  output logic signed [31:0] Angle,
  output logic signed [31:0] Residual,
  output logic               Ovf
);

  localparam int DATA_W = 32;
  localparam logic signed [DATA_W-1:0] DEG180 = 32'sd11796480;
  localparam logic signed [DATA_W-1:0] LIMIT  = 32'sd536870912;

  // atan(2^-i) in degrees * 2^16
  localparam logic signed [DATA_W-1:0] ROT [16] = '{
    32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
    32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
    32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
    32'sd896,     32'sd448,     32'sd256,    32'sd128
  };

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_SCALE, ST_DONE} state_t;

  state_t                    state_q;
  logic               [4:0]  iter_q;
  logic signed [DATA_W-1:0]  x_q, y_q, z_q;
  logic                      zero_q;
  logic                      in_rdy_q, out_vld_q, ovf_q;
  logic        [DATA_W-1:0]  mag_q;
  logic signed [DATA_W-1:0]  ang_q, res_q;

  logic signed [DATA_W-1:0]  x_d, y_d, z_d;
  logic signed [DATA_W-1:0]  fx_d, fy_d, fz_d;
  logic                      big_d;

  // Beyond +/-2^29 the gain-expanded x no longer fits 32 bits.
  function automatic logic out_of_range(input logic signed [DATA_W-1:0] v);
    return (v >= LIMIT) || (v <= -LIMIT);
  endfunction

  // Remove the CORDIC gain: middle 32 bits of the 64-bit signed x*K.
  function automatic logic [DATA_W-1:0] scale_gain(input logic signed [DATA_W-1:0] v);
    logic signed [63:0] ve;
    logic signed [63:0] ke;
    logic signed [63:0] prod;
    ve   = {{32{v[31]}}, v};
    ke   = {{32{K[31]}}, K};
    prod = ve * ke;
    return 32'(prod >>> 16);
  endfunction

  // Fold the left half-plane onto the right so the rotations converge.
  always_comb begin
    big_d = out_of_range(X_In) || out_of_range(Y_In);
    fx_d  = X_In;
    fy_d  = Y_In;
    fz_d  = '0;
    if (X_In[31]) begin
      fx_d = -X_In;
      fy_d = -Y_In;
      fz_d = Y_In[31] ? -DEG180 : DEG180;
    end
  end

  // One micro-rotation driving y towards zero, all terms from old values.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (!y_q[31]) begin
      x_d = x_q + (y_q >>> iter_q);
      y_d = y_q - (x_q >>> iter_q);
      z_d = z_q + ROT[iter_q[3:0]];
    end else begin
      x_d = x_q - (y_q >>> iter_q);
      y_d = y_q + (x_q >>> iter_q);
      z_d = z_q - ROT[iter_q[3:0]];
    end
  end

  // Control FSM together with the iteration and result registers.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      mag_q     <= '0;
      ang_q     <= '0;
      res_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (In_Valid && in_rdy_q) begin
            x_q      <= fx_d;
            y_q      <= fy_d;
            z_q      <= fz_d;
            ovf_q    <= big_d;
            zero_q   <= (X_In == '0) && (Y_In == '0);
            iter_q   <= '0;
            in_rdy_q <= 1'b0;
            state_q  <= ST_ITER;
          end
        end
        ST_ITER: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'(ITER - 1)) begin
            state_q <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          if (zero_q) begin
            mag_q <= '0;
            ang_q <= '0;
            res_q <= '0;
          end else begin
            mag_q <= scale_gain(x_q);
            ang_q <= z_q;
            res_q <= y_q;
          end
          out_vld_q <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (Out_Ready) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign In_Ready  = in_rdy_q;
  assign Out_Valid = out_vld_q;
  assign Magnitude = mag_q;
  assign Angle     = ang_q;
  assign Residual  = res_q;
  assign Ovf       = ovf_q;

endmodule
